// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns line-granular cache requests (pmem_*) into
// BEATS-beat bursts on a BURST_W-wide memory interface and returns one
// pmem_resp pulse per completed line.
// Build option: define CLA_TIMEOUT_EN to add a per-beat watchdog. When it
// expires, the adaptor raises a sticky burst_err and forces completion.
module cacheline_adaptor #(
  parameter int unsigned LINE_W         = 256,
  parameter int unsigned BURST_W        = 64,
  parameter int unsigned BEATS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pmem_address,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [31:0]        burst_address,
  output logic               burst_read,
  output logic               burst_write,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
`ifdef CLA_TIMEOUT_EN
  ,
  output logic               burst_err
`endif
);

  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned WBUF_W = LINE_W - BURST_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Reject configurations where the line does not split evenly into beats.
  if ((LINE_W != BEATS * BURST_W) || (BEATS < 2) || (TIMEOUT_CYCLES == 0)) begin : g_cfg_check
    $error("cacheline_adaptor: inconsistent LINE_W/BURST_W/BEATS/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [31:0]         addr_q;
  logic [WBUF_W-1:0]   wbuf_q;
  logic [BURST_W-1:0]  wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                pmem_resp_q;
  logic                burst_read_q;
  logic                burst_write_q;
  logic [CNT_W-1:0]    count_nxt_c;
  logic                last_beat_c;

  // Byte offset within the line never reaches the burst side.
  logic addr_offset_unused;
  assign addr_offset_unused = ^pmem_address[OFF_W-1:0];

  assign count_nxt_c = count_q + CNT_W'(1);
  assign last_beat_c = burst_resp && (count_q == LAST_BEAT);

`ifdef CLA_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            wd_expire_c;

  // Watchdog fires when the idle count is about to reach TIMEOUT_CYCLES.
  assign wd_expire_c = !burst_resp && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign burst_err   = err_q;
`endif

  // Line FSM: accepts a request, runs the beats, pulses pmem_resp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      addr_q        <= '0;
      wbuf_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      pmem_resp_q   <= 1'b0;
      burst_read_q  <= 1'b0;
      burst_write_q <= 1'b0;
`ifdef CLA_TIMEOUT_EN
      wd_q          <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          pmem_resp_q <= 1'b0;
          // Writeback wins when both requests are presented together.
          if (pmem_write) begin
            state_q       <= ST_WR;
            addr_q        <= {pmem_address[31:OFF_W], OFF_W'(0)};
            wbuf_q        <= pmem_wdata[LINE_W-1:BURST_W];
            wdata_q       <= pmem_wdata[BURST_W-1:0];
            count_q       <= '0;
            burst_write_q <= 1'b1;
`ifdef CLA_TIMEOUT_EN
            wd_q          <= '0;
`endif
          end else if (pmem_read) begin
            state_q      <= ST_RD;
            addr_q       <= {pmem_address[31:OFF_W], OFF_W'(0)};
            count_q      <= '0;
            burst_read_q <= 1'b1;
`ifdef CLA_TIMEOUT_EN
            wd_q         <= '0;
`endif
          end
        end

        ST_RD: begin
          if (burst_resp) begin
            for (int b = 0; b < int'(BEATS); b++) begin
              if (count_q == CNT_W'(b)) begin
                rdata_q[b*BURST_W +: BURST_W] <= burst_rdata;
              end
            end
`ifdef CLA_TIMEOUT_EN
            wd_q <= '0;
`endif
            if (last_beat_c) begin
              state_q      <= ST_DONE;
              count_q      <= '0;
              burst_read_q <= 1'b0;
              pmem_resp_q  <= 1'b1;
            end else begin
              count_q <= count_nxt_c;
            end
          end
`ifdef CLA_TIMEOUT_EN
          else if (wd_expire_c) begin
            err_q        <= 1'b1;
            state_q      <= ST_DONE;
            count_q      <= '0;
            burst_read_q <= 1'b0;
            pmem_resp_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end

        ST_WR: begin
          if (burst_resp) begin
            // Present the following beat; beat 0 was loaded on acceptance.
            for (int b = 1; b < int'(BEATS); b++) begin
              if (count_nxt_c == CNT_W'(b)) begin
                wdata_q <= wbuf_q[(b-1)*BURST_W +: BURST_W];
              end
            end
`ifdef CLA_TIMEOUT_EN
            wd_q <= '0;
`endif
            if (last_beat_c) begin
              state_q       <= ST_DONE;
              count_q       <= '0;
              burst_write_q <= 1'b0;
              pmem_resp_q   <= 1'b1;
            end else begin
              count_q <= count_nxt_c;
            end
          end
`ifdef CLA_TIMEOUT_EN
          else if (wd_expire_c) begin
            err_q         <= 1'b1;
            state_q       <= ST_DONE;
            count_q       <= '0;
            burst_write_q <= 1'b0;
            pmem_resp_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end

        ST_DONE: begin
          // Single-cycle response; the cache drops its request meanwhile.
          pmem_resp_q <= 1'b0;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q       <= ST_IDLE;
          pmem_resp_q   <= 1'b0;
          burst_read_q  <= 1'b0;
          burst_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_rdata    = rdata_q;
  assign pmem_resp     = pmem_resp_q;
  assign burst_address = addr_q;
  assign burst_read    = burst_read_q;
  assign burst_write   = burst_write_q;
  assign burst_wdata   = wdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: reactive memory model plus scoreboard queues
// of expected read lines and write beats.
module tb_cacheline_adaptor;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned BEATS   = 4;
`ifdef CLA_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        pmem_address;
  logic               pmem_read;
  logic               pmem_write;
  logic [LINE_W-1:0]  pmem_wdata;
  logic [LINE_W-1:0]  pmem_rdata;
  logic               pmem_resp;
  logic [31:0]        burst_address;
  logic               burst_read;
  logic               burst_write;
  logic [BURST_W-1:0] burst_wdata;
  logic [BURST_W-1:0] burst_rdata;
  logic               burst_resp;
`ifdef CLA_TIMEOUT_EN
  logic               burst_err;
`endif

  always #5 clk = ~clk;

  cacheline_adaptor #(
    .LINE_W(LINE_W), .BURST_W(BURST_W), .BEATS(BEATS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
`ifdef CLA_TIMEOUT_EN
    , .burst_err(burst_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [LINE_W-1:0]  rline_q[$];
  logic [BURST_W-1:0] wbeat_q[$];
  logic [LINE_W-1:0]  last_rline = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One line transaction; pat bit i = burst_resp in the i-th requesting cycle.
  task automatic run_txn(input string name, input bit wr, input bit rd,
                         input logic [31:0] addr, input logic [LINE_W-1:0] line,
                         input logic [15:0] pat, input int exp_resp);
    logic [31:0]        exp_addr;
    logic [LINE_W-1:0]  exp_line;
    logic [BURST_W-1:0] exp_beat;
    int  cyc = 0;
    int  beat = 0;
    int  idx = 0;
    int  req_cycles = 0;
    bit  done = 0;
    exp_addr = {addr[31:5], 5'b0};
    if (wr) begin
      for (int b = 0; b < int'(BEATS); b++) wbeat_q.push_back(line[b*BURST_W +: BURST_W]);
    end else begin
      rline_q.push_back(line);
    end
    pmem_address = addr;
    pmem_wdata   = line;
    pmem_read    = rd;
    pmem_write   = wr;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      burst_resp  = 1'b0;
      burst_rdata = {$urandom, $urandom};
      if (cyc == 1) begin
        pmem_address = ~addr;
        pmem_wdata   = ~line;
      end
      if (pmem_resp) begin
        done = 1;
        check({name, " resp cycle"}, 256'(cyc), 256'(exp_resp));
        check({name, " req low in done"}, 256'({burst_read, burst_write}), 256'(0));
        check({name, " req cycles"}, 256'(req_cycles), 256'(exp_resp - 1));
        if (wr) begin
          check({name, " rdata untouched"}, pmem_rdata, last_rline);
        end else if (rline_q.size() > 0) begin
          exp_line = rline_q.pop_front();
          check({name, " rdata"}, pmem_rdata, exp_line);
          last_rline = exp_line;
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end else if (burst_read || burst_write) begin
        req_cycles++;
        check({name, " req kind"}, 256'({burst_write, burst_read}), 256'(wr ? 2'b10 : 2'b01));
        check({name, " addr"}, 256'(burst_address), 256'(exp_addr));
        if (beat < int'(BEATS) && (idx >= 16 || pat[idx])) begin
          burst_resp = 1'b1;
          if (wr) begin
            if (wbeat_q.size() > 0) begin
              exp_beat = wbeat_q.pop_front();
              check({name, " wdata beat"}, 256'(burst_wdata), 256'(exp_beat));
            end
          end else begin
            burst_rdata = line[beat*BURST_W +: BURST_W];
          end
          beat++;
        end
        idx++;
      end
    end
    if (!done) check({name, " resp timeout"}, 256'(0), 256'(1));
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    burst_resp = 1'b0;
    @(posedge clk); #1;
    check({name, " resp single pulse"}, 256'(pmem_resp), 256'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, " pmem_resp"}, 256'(pmem_resp), 256'(0));
    check({name, " burst req"}, 256'({burst_read, burst_write}), 256'(0));
    check({name, " burst_address"}, 256'(burst_address), 256'(0));
    check({name, " burst_wdata"}, 256'(burst_wdata), 256'(0));
    check({name, " pmem_rdata"}, pmem_rdata, 256'(0));
`ifdef CLA_TIMEOUT_EN
    check({name, " burst_err"}, 256'(burst_err), 256'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit: got timeout, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [LINE_W-1:0] l_a, l_w, l_g, l_r;
    rst = 1'b0; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    l_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_txn("rd b2b", 1'b0, 1'b1, 32'h0000_1234, l_a, 16'hFFFF, 5);
    check("rd b2b line addr", 256'(burst_address), 256'(32'h0000_1220));

    l_w = {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
           64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000};
    run_txn("wr b2b", 1'b1, 1'b0, 32'h8000_0040, l_w, 16'hFFFF, 5);

    for (int i = 0; i < 8; i++) l_g[i*32 +: 32] = $urandom;
    run_txn("rd gapped", 1'b0, 1'b1, 32'hABCD_EF7F, l_g, 16'h0059, 8);

    for (int i = 0; i < 8; i++) l_w[i*32 +: 32] = $urandom;
    run_txn("rd+wr prio", 1'b1, 1'b1, 32'h0000_0FE0, l_w, 16'hFFFF, 5);

    for (int i = 0; i < 8; i++) l_w[i*32 +: 32] = $urandom;
    run_txn("wr gapped", 1'b1, 1'b0, 32'h1234_5678, l_w, 16'h004D, 8);

    // Abort a read after two beats with an asynchronous reset.
    pmem_address = 32'h0000_2000; pmem_read = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      burst_resp = 1'b1; burst_rdata = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    burst_resp = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("async reset");
    pmem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_rline = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("no resp after abort", 256'({pmem_resp, burst_read, burst_write}), 256'(0));
    end

    for (int i = 0; i < 8; i++) l_r[i*32 +: 32] = $urandom;
    run_txn("rd after reset", 1'b0, 1'b1, 32'h0000_2000, l_r, 16'hFFFF, 5);

`ifdef CLA_TIMEOUT_EN
    begin
      int cyc = 0;
      bit seen = 0;
      pmem_address = 32'h0000_3000; pmem_read = 1'b1;
      while (!seen && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (cyc == 1) check("tmo err low early", 256'(burst_err), 256'(0));
        if (pmem_resp) begin
          seen = 1;
          check("tmo resp cycle", 256'(cyc), 256'(TMO + 1));
          check("tmo err set", 256'(burst_err), 256'(1));
          pmem_read = 1'b0;
        end
      end
      if (!seen) check("tmo resp missing", 256'(0), 256'(1));
      pmem_read = 1'b0;
      @(posedge clk); #1;
      check("tmo resp single", 256'(pmem_resp), 256'(0));
      run_txn("rd after tmo", 1'b0, 1'b1, 32'h0000_4000, l_a, 16'hFFFF, 5);
      check("tmo err sticky", 256'(burst_err), 256'(1));
      rst = 1'b0;
      #1;
      check("tmo err cleared", 256'(burst_err), 256'(0));
      @(posedge clk); #1;
      rst = 1'b1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
